// File: rtl/div_req_sequencer.sv
// rtl/div_req_sequencer.sv - valid/ready request/response sequencer around a restoring divider
// Optional result counters (stat_ok/stat_err) when DIV_REQ_SEQ_STATS_EN is defined.
module div_req_sequencer #(
  parameter int WIDTH     = 10,
  parameter int BUSY_WAIT = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             div_start,
  output logic [WIDTH-1:0] div_a,
  output logic [WIDTH-1:0] div_b,
  input  logic             div_busy,
  input  logic             div_valid,
  input  logic [WIDTH-1:0] div_q,
  input  logic [WIDTH-1:0] div_r,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_q,
  output logic [WIDTH-1:0] out_r,
  output logic [1:0]       out_err
`ifdef DIV_REQ_SEQ_STATS_EN
  ,
  output logic [15:0]      stat_ok,
  output logic [15:0]      stat_err
`endif
);

  localparam int CW = $clog2(BUSY_WAIT + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_ISSUE, S_WAIT_BUSY, S_WAIT_DONE, S_OUTPUT
  } state_t;

  state_t           r_state, w_next;
  logic             r_up;
  logic [CW-1:0]    r_wait;
  logic [WIDTH-1:0] r_a, r_b, r_q, r_r;
  logic [1:0]       r_err;

  logic             w_ld_in, w_ld_res, w_clr_wait, w_inc_wait;
  logic [WIDTH-1:0] w_res_q, w_res_r;
  logic [1:0]       w_res_err;

  // r_up keeps in_ready low until the first clock after reset release
  assign in_ready  = r_up && (r_state == S_IDLE);
  assign div_start = (r_state == S_ISSUE);
  assign out_valid = (r_state == S_OUTPUT);
  assign div_a     = r_a;
  assign div_b     = r_b;
  assign out_q     = r_q;
  assign out_r     = r_r;
  assign out_err   = r_err;

  always_comb begin
    w_next     = r_state;
    w_ld_in    = 1'b0;
    w_ld_res   = 1'b0;
    w_clr_wait = 1'b0;
    w_inc_wait = 1'b0;
    w_res_q    = '0;
    w_res_r    = '0;
    w_res_err  = 2'b00;
    case (r_state)
      S_IDLE: begin
        if (r_up && in_valid) begin
          w_ld_in = 1'b1;
          if (in_b == '0) begin
            w_ld_res  = 1'b1;
            w_res_r   = in_a;
            w_res_err = 2'b01;
            w_next    = S_OUTPUT;
          end else begin
            w_next = S_ISSUE;
          end
        end
      end
      S_ISSUE: begin
        w_clr_wait = 1'b1;
        w_next     = S_WAIT_BUSY;
      end
      S_WAIT_BUSY: begin
        if (div_busy) begin
          w_next = S_WAIT_DONE;
        end else if (r_wait == CW'(BUSY_WAIT - 1)) begin
          w_ld_res  = 1'b1;
          w_res_err = 2'b11;
          w_next    = S_OUTPUT;
        end else begin
          w_inc_wait = 1'b1;
        end
      end
      S_WAIT_DONE: begin
        // a completing pulse wins over busy dropping in the same cycle
        if (div_valid) begin
          w_ld_res = 1'b1;
          w_res_q  = div_q;
          w_res_r  = div_r;
          w_next   = S_OUTPUT;
        end else if (!div_busy) begin
          w_ld_res  = 1'b1;
          w_res_err = 2'b10;
          w_next    = S_OUTPUT;
        end
      end
      S_OUTPUT: begin
        if (out_ready) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_up    <= 1'b0;
      r_wait  <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_q     <= '0;
      r_r     <= '0;
      r_err   <= 2'b00;
    end else begin
      r_state <= w_next;
      r_up    <= 1'b1;
      if (w_clr_wait)      r_wait <= '0;
      else if (w_inc_wait) r_wait <= r_wait + 1'b1;
      if (w_ld_in) begin
        r_a <= in_a;
        r_b <= in_b;
      end
      if (w_ld_res) begin
        r_q   <= w_res_q;
        r_r   <= w_res_r;
        r_err <= w_res_err;
      end
    end
  end

`ifdef DIV_REQ_SEQ_STATS_EN
  logic [15:0] r_stat_ok, r_stat_err;
  logic        w_accept;

  assign w_accept = (r_state == S_OUTPUT) && out_ready;
  assign stat_ok  = r_stat_ok;
  assign stat_err = r_stat_err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stat_ok  <= '0;
      r_stat_err <= '0;
    end else if (w_accept) begin
      if (r_err == 2'b00) begin
        if (r_stat_ok != 16'hFFFF) r_stat_ok <= r_stat_ok + 16'd1;
      end else begin
        if (r_stat_err != 16'hFFFF) r_stat_err <= r_stat_err + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_div_req_sequencer.sv
// tb/tb_div_req_sequencer.sv - table-driven scoreboard bench for div_req_sequencer
module tb_div_req_sequencer;
  localparam int W  = 10;
  localparam int BW = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         in_valid = 1'b0, out_ready = 1'b0, div_busy = 1'b0, div_valid = 1'b0;
  logic [W-1:0] in_a = '0, in_b = '0, div_q = '0, div_r = '0;
  logic         in_ready, div_start, out_valid;
  logic [W-1:0] div_a, div_b, out_q, out_r;
  logic [1:0]   out_err;
`ifdef DIV_REQ_SEQ_STATS_EN
  logic [15:0]  stat_ok, stat_err;
`endif

  always #5 clk = ~clk;

  div_req_sequencer #(.WIDTH(W), .BUSY_WAIT(BW)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .div_start(div_start), .div_a(div_a), .div_b(div_b),
    .div_busy(div_busy), .div_valid(div_valid), .div_q(div_q), .div_r(div_r),
    .out_valid(out_valid), .out_ready(out_ready), .out_q(out_q), .out_r(out_r),
    .out_err(out_err)
`ifdef DIV_REQ_SEQ_STATS_EN
    , .stat_ok(stat_ok), .stat_err(stat_err)
`endif
  );

  typedef struct {
    logic [W-1:0] a, b;
    int           mode;   // 0 normal, 1 abort, 2 never busy
    int           hold;
    logic [W-1:0] q, r;
    logic [1:0]   err;
    int           lat;    // <=0: not checked
  } vec_t;

  typedef struct {
    logic [W-1:0] q, r;
    logic [1:0]   err;
  } res_t;

  res_t sb[$];
  vec_t vt[12];
  int   n_pass = 0, n_total = 0;
  int   m_t = -1, m_mode = 0, starts = 0, exp_ok = 0, exp_err = 0;
  logic [W-1:0] m_a, m_b;

  function automatic vec_t mk(int a, int b, int mode, int hold, int q, int r, int err, int lat);
    vec_t v;
    v.a = W'(a); v.b = W'(b); v.mode = mode; v.hold = hold;
    v.q = W'(q); v.r = W'(r); v.err = 2'(err); v.lat = lat;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  // one clock: advance, then update the divider model away from the edge
  task automatic step();
    @(posedge clk); #1;
    if (m_t >= 0) m_t++;
    if (div_start) begin
      m_t = 0; m_a = div_a; m_b = div_b; starts++;
    end
    div_valid = 1'b0;
    if (m_t >= 0 && m_mode != 2) begin
      if (m_t == 2) div_busy = 1'b1;
      if (m_mode == 0 && m_t == 12) begin
        div_busy = 1'b0; div_valid = 1'b1;
        div_q = m_a / m_b; div_r = m_a % m_b; m_t = -1;
      end else if (m_mode == 1 && m_t == 6) begin
        div_busy = 1'b0; m_t = -1;
      end
    end
  endtask

  task automatic run_vec(input vec_t v);
    res_t e;
    int   lat, guard;
    m_mode = v.mode; starts = 0;
    in_a = v.a; in_b = v.b; in_valid = 1'b1;
    guard = 0;
    while (!in_ready && guard < 50) begin step(); guard++; end
    chk("accept_ready", in_ready, 1);
    e.q = v.q; e.r = v.r; e.err = v.err;
    sb.push_back(e);
    step();
    in_valid = 1'b0; in_a = W'($urandom); in_b = W'($urandom);
    lat = 1;
    while (!out_valid && lat < 100) begin step(); lat++; end
    chk("out_valid", out_valid, 1);
    if (v.lat > 0) chk("latency", lat, v.lat);
    for (int h = 0; h < v.hold; h++) begin
      in_valid = 1'b1;
      step();
      chk("hold", {out_valid, in_ready, out_err, out_q, out_r, div_a},
                  {1'b1, 1'b0, v.err, v.q, v.r, v.a});
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    chk("sb_nonempty", sb.size() != 0, 1);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      chk("q", out_q, e.q);
      chk("r", out_r, e.r);
      chk("err", out_err, e.err);
      if (e.err == 2'b00) exp_ok++; else exp_err++;
    end
    step();
    out_ready = 1'b0;
    chk("drop", {out_valid, in_ready}, 2'b01);
    chk("starts", starts, (v.b == 0) ? 0 : 1);
  endtask

  initial begin
    int bad;
    vt[0] = mk(100, 7, 0, 0, 14, 2, 0, -1);
    vt[1] = mk(55, 0, 0, 0, 0, 55, 1, 1);
    vt[2] = mk(50, 5, 1, 0, 0, 0, 2, -1);
    vt[3] = mk(77, 3, 2, 0, 0, 0, 3, 2 + BW);
    vt[4] = mk(9, 3, 0, 5, 3, 0, 0, -1);
    vt[5] = mk(1023, 1, 0, 0, 1023, 0, 0, -1);
    vt[6] = mk(5, 9, 0, 2, 0, 5, 0, -1);
    vt[7] = mk(0, 0, 0, 3, 0, 0, 1, 1);
    for (int i = 8; i < 12; i++) begin
      int a, b;
      a = int'($urandom_range(0, 1023));
      b = int'($urandom_range(1, 1023));
      vt[i] = mk(a, b, 0, i - 8, a / b, a % b, 0, -1);
    end

    #2 rst_n = 1'b0;
    #1;
    chk("rst_state", {in_ready, out_valid, div_start, out_err, out_q, out_r, div_a, div_b}, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    step();
    chk("rst_release_ready", in_ready, 1);

    for (int i = 0; i < 12; i++) begin
      run_vec(vt[i]);
      step();
    end

    // reset during WAIT_DONE, then a late div_valid from the divider
    m_mode = 0; starts = 0;
    in_a = 10'd100; in_b = 10'd7; in_valid = 1'b1;
    chk("mid_accept_ready", in_ready, 1);
    step();
    in_valid = 1'b0;
    repeat (6) step();
    #1 rst_n = 1'b0;
    #1;
    chk("mid_rst_async", {in_ready, out_valid, div_start, out_err, out_q, out_r, div_a, div_b}, 0);
    step(); step();
    rst_n = 1'b1;
    step();
    chk("mid_rst_ready", in_ready, 1);
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (out_valid || div_start || !in_ready) bad++;
    end
    chk("late_valid_ignored", bad, 0);
    chk("mid_rst_starts", starts, 1);
    exp_ok = 0; exp_err = 0;
    div_busy = 1'b0;

    run_vec(vt[0]);
    run_vec(vt[3]);
`ifdef DIV_REQ_SEQ_STATS_EN
    chk("stat_ok", stat_ok, exp_ok);
    chk("stat_err", stat_err, exp_err);
`endif
    chk("sb_empty", sb.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
